// File: rtl/axi_ram_slave_if.sv
// rtl/axi_ram_slave_if.sv - AXI3 bus bundle for the RAM responder
// Carries the AR/R/AW/W/B channels; clock and reset stay plain ports on the modules.
// Modports: slave (the RAM responder), master (the requester driving it).
interface axi_ram_slave_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 burst responder over a word-addressed internal RAM
// Ports: aclk (rising edge), aresetn (async active-low), bus (axi_ram_slave_if.slave).
// One transaction at a time; INCR/FIXED/WRAP bursts; byte strobes on writes.
// Optional macro AXI_RAM_RAND_STALL_EN: LFSR-driven bubbles on rvalid/wready.
module axi_ram_slave #(
    parameter int MEM_ADDR_LEN = 12,
    parameter int ID_WIDTH     = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_ram_slave_if.slave   bus
);
    localparam int DEPTH = 1 << MEM_ADDR_LEN;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [MEM_ADDR_LEN-1:0] word_idx;
    logic [31:0] inc, wmask, addr_inc, addr_next;
    logic        wrap_ok, last_beat, rd_fire, wr_fire, rd_stall, wr_stall;

    // Upper address bits alias; wid carries no information for this slave.
    logic unused_ok;
    assign unused_ok = ^bus.wid;

    assign word_idx  = addr_q[MEM_ADDR_LEN+1:2];
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        inc       = 32'd1 << size_q;
        wmask     = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
        addr_inc  = addr_q + inc;
        wrap_ok   = (burst_q == 2'b10) &&
                    (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
        addr_next = addr_inc;
        if (burst_q == 2'b00)
            addr_next = addr_q;
        else if (wrap_ok)
            addr_next = (addr_q & ~wmask) | (addr_inc & wmask);
    end

`ifdef AXI_RAM_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic        rv_hold_q;

    // Once a read beat is shown it stays up until taken, so only the first
    // presentation of each beat can be stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q    <= 16'hACE1;
            rv_hold_q <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            rv_hold_q <= bus.rvalid && !bus.rready;
        end
    end

    assign rd_stall = (lfsr_q[1:0] == 2'b00) && !rv_hold_q;
    assign wr_stall = (lfsr_q[1:0] == 2'b00);
`else
    assign rd_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    // Ready outputs are gated by reset so they read low while aresetn is held.
    assign bus.arready = aresetn && (state_q == S_IDLE);
    assign bus.awready = aresetn && (state_q == S_IDLE) && !bus.arvalid;
    assign bus.rvalid  = (state_q == S_RD) && !rd_stall;
    assign bus.rdata   = mem[word_idx];
    assign bus.rid     = (state_q == S_RD) ? id_q : '0;
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = (state_q == S_RD) && last_beat;
    assign bus.wready  = (state_q == S_WR) && !wr_stall;
    assign bus.bvalid  = (state_q == S_WRESP);
    assign bus.bid     = (state_q == S_WRESP) ? id_q : '0;
    assign bus.bresp   = (state_q == S_WRESP && err_q) ? 2'b10 : 2'b00;

    assign rd_fire = bus.rvalid && bus.rready;
    assign wr_fire = bus.wvalid && bus.wready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (bus.arvalid) begin
                    state_d = S_RD;
                    addr_d  = bus.araddr;
                    len_d   = bus.arlen;
                    size_d  = (bus.arsize > 3'd2) ? 2'd2 : bus.arsize[1:0];
                    burst_d = bus.arburst;
                    id_d    = bus.arid;
                end else if (bus.awvalid) begin
                    state_d = S_WR;
                    addr_d  = bus.awaddr;
                    len_d   = bus.awlen;
                    size_d  = (bus.awsize > 3'd2) ? 2'd2 : bus.awsize[1:0];
                    burst_d = bus.awburst;
                    id_d    = bus.awid;
                end
            end
            S_RD: begin
                if (rd_fire) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_beat)
                        state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (wr_fire) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 8'd1;
                    // Burst length follows awlen; a misplaced wlast only flags an error.
                    if (bus.wlast != last_beat)
                        err_d = 1'b1;
                    if (last_beat)
                        state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bus.bready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            size_q  <= 2'd0;
            burst_q <= 2'd0;
            id_q    <= '0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // RAM contents are not reset.
    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i])
                    mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - scoreboard testbench for axi_ram_slave
module tb_axi_ram_slave;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_ram_slave_if #(.ID_WIDTH(4)) bus();

    axi_ram_slave #(.MEM_ADDR_LEN(12), .ID_WIDTH(4)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] model_mem [0:4095];
    logic [31:0] exp_q [$];
    logic [31:0] rd_data [$];
    logic        rd_last [$];
    logic [3:0]  rd_id [$];
    int          rd_lat, rd_cycles;
    time         ar_time, aw_time;
    logic [31:0] wr_data [$];
    logic [3:0]  wr_strb [$];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    int          w_beats;

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % 4096);
    endfunction

    function automatic logic [31:0] nxt_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        int s;
        longint unsigned n, tot, base;
        s = (size > 3'd2) ? 2 : int'(size);
        if (burst == 2'b00) return a;
        n = 64'(a) + (64'd1 << s);
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            tot  = (64'(len) + 64'd1) << s;
            base = 64'(a) - (64'(a) % tot);
            if (n >= base + tot) n = base;
        end
        return n[31:0];
    endfunction

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit rand_rdy);
        logic [31:0] a;
        int t, cyc, beats;
        a = addr;
        exp_q.delete(); rd_data.delete(); rd_last.delete(); rd_id.delete();
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(model_mem[midx(a)]);
            a = nxt_addr(a, len, size, burst);
        end
        @(posedge aclk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!bus.arready && t < 100) begin @(negedge aclk); t++; end
        if (!bus.arready) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout got arready=0 exp 1");
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge aclk); ar_time = $time; #1;
        bus.arvalid = 1'b0;
        bus.rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0; beats = 0; rd_lat = -1;
        while (beats <= int'(len) && cyc < 2000) begin
            @(negedge aclk); cyc++;
            if (bus.rvalid && rd_lat < 0) rd_lat = cyc;
            if (bus.rvalid && bus.rready) begin
                rd_data.push_back(bus.rdata); rd_last.push_back(bus.rlast);
                rd_id.push_back(bus.rid); beats++;
            end
            @(posedge aclk); #1;
            bus.rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        bus.rready = 1'b1;
        rd_cycles = cyc;
        if (beats <= int'(len)) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout got %0d beats exp %0d", beats, int'(len) + 1);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
        logic [31:0] a;
        int t, idx;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            idx = midx(a);
            for (int b = 0; b < 4; b++)
                if (wr_strb[i][b]) model_mem[idx][8*b +: 8] = wr_data[i][8*b +: 8];
            a = nxt_addr(a, len, size, burst);
        end
        w_beats = 0;
        @(posedge aclk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!bus.awready && t < 100) begin @(negedge aclk); t++; end
        if (!bus.awready) begin
            n_tests++; n_fail++;
            $display("FAIL aw_timeout got awready=0 exp 1");
            bus.awvalid = 1'b0;
            return;
        end
        @(posedge aclk); aw_time = $time; #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1; bus.wdata = wr_data[i]; bus.wstrb = wr_strb[i];
            bus.wid = id; bus.wlast = (i == wlast_at);
            t = 0;
            @(negedge aclk);
            while (!bus.wready && t < 100) begin @(negedge aclk); t++; end
            if (!bus.wready) begin
                n_tests++; n_fail++;
                $display("FAIL w_timeout got wready=0 exp 1 at beat %0d", i);
                bus.wvalid = 1'b0;
                return;
            end
            @(posedge aclk); #1;
            w_beats++;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        t = 0;
        @(negedge aclk);
        while (!bus.bvalid && t < 100) begin @(negedge aclk); t++; end
        if (!bus.bvalid) begin
            n_tests++; n_fail++;
            $display("FAIL b_timeout got bvalid=0 exp 1");
            return;
        end
        b_resp = bus.bresp; b_id = bus.bid;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if ({bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 000000", {bus.arready, bus.awready, bus.rvalid,
                     bus.rlast, bus.wready, bus.bvalid});
        end
        n_tests++;
        if ({bus.rid, bus.bid, bus.rresp, bus.bresp} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_payload got %h exp 000", {bus.rid, bus.bid, bus.rresp, bus.bresp});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (bus.arready !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle_arready got %b exp 1", bus.arready);
        end
    endtask

    task automatic test_incr_read;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 8; i++) begin wr_data.push_back(32'(i)); wr_strb.push_back(4'hF); end
        axi_write(4'h1, 32'h100, 8'd7, 3'd2, 2'b01, 7);
        axi_read(4'h5, 32'h100, 8'd7, 3'd2, 2'b01, 1'b0);
        n_tests++;
        if (rd_lat !== 1) begin n_fail++; $display("FAIL incr_latency got %0d exp 1", rd_lat); end
        n_tests++;
        if (rd_cycles !== 8) begin n_fail++; $display("FAIL incr_cycles got %0d exp 8", rd_cycles); end
        n_tests++;
        if (rd_data.size() !== 8) begin
            n_fail++; $display("FAIL incr_beats got %0d exp 8", rd_data.size());
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e) begin
                n_fail++; $display("FAIL incr_rdata[%0d] got %h exp %h", i, rd_data[i], e);
            end
            n_tests++;
            if (rd_last[i] !== (i == 7)) begin
                n_fail++; $display("FAIL incr_rlast[%0d] got %b exp %b", i, rd_last[i], i == 7);
            end
            n_tests++;
            if (rd_id[i] !== 4'h5) begin
                n_fail++; $display("FAIL incr_rid[%0d] got %h exp 5", i, rd_id[i]);
            end
        end
        n_tests++;
        if (rd_data.size() > 3 && rd_data[3] !== 32'd3) begin
            n_fail++; $display("FAIL incr_word3 got %h exp 00000003", rd_data[3]);
        end
        @(negedge aclk);
        n_tests++;
        if (bus.arready !== 1'b1) begin
            n_fail++; $display("FAIL incr_back_idle got arready=%b exp 1", bus.arready);
        end
    endtask

    task automatic test_incr_write;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 8; i++) begin wr_data.push_back(32'hA0 + 32'(i)); wr_strb.push_back(4'hF); end
        axi_write(4'h9, 32'h200, 8'd7, 3'd2, 2'b01, 7);
        n_tests++;
        if (b_resp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp got %b exp 00", b_resp); end
        n_tests++;
        if (b_id !== 4'h9) begin n_fail++; $display("FAIL wr_bid got %h exp 9", b_id); end
        axi_read(4'h2, 32'h200, 8'd7, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e || rd_data[i] !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL wr_readback[%0d] got %h exp %h", i, rd_data[i], e);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        axi_read(4'h3, 32'h108, 8'd3, 3'd2, 2'b10, 1'b0);
        n_tests++;
        if (rd_data.size() !== 4) begin n_fail++; $display("FAIL wrap_beats got %0d exp 4", rd_data.size()); end
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e) begin
                n_fail++; $display("FAIL wrap_rdata[%0d] got %h exp %h", i, rd_data[i], e);
            end
        end
        n_tests++;
        if (rd_data.size() === 4 && (rd_data[0] !== 32'd2 || rd_data[2] !== 32'd0)) begin
            n_fail++; $display("FAIL wrap_order got %h,%h exp 2,0", rd_data[0], rd_data[2]);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        wr_data.push_back(32'hFFFF_FFFF); wr_strb.push_back(4'hF);
        axi_write(4'h4, 32'h400, 8'd0, 3'd2, 2'b01, 0);
        wr_data.delete(); wr_strb.delete();
        wr_data.push_back(32'h1122_3344); wr_strb.push_back(4'b0101);
        axi_write(4'h4, 32'h400, 8'd0, 3'd2, 2'b01, 0);
        axi_read(4'h4, 32'h400, 8'd0, 3'd2, 2'b01, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (rd_data.size() !== 1 || rd_data[0] !== e || rd_data[0] !== 32'hFF22_FF44) begin
            n_fail++; $display("FAIL strobe_word got %h exp ff22ff44", rd_data.size() ? rd_data[0] : 32'hx);
        end
    endtask

    task automatic test_wlast_err;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 4; i++) begin wr_data.push_back(32'h5000 + 32'(i)); wr_strb.push_back(4'hF); end
        axi_write(4'h6, 32'h500, 8'd3, 3'd2, 2'b01, 2);
        n_tests++;
        if (w_beats !== 4) begin n_fail++; $display("FAIL wlast_beats got %0d exp 4", w_beats); end
        n_tests++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wlast_bresp got %b exp 10", b_resp); end
        wr_data.delete(); wr_strb.delete();
        wr_data.push_back(32'h600D_0000); wr_strb.push_back(4'hF);
        axi_write(4'h7, 32'h510, 8'd0, 3'd2, 2'b01, 0);
        n_tests++;
        if (b_resp !== 2'b00) begin n_fail++; $display("FAIL wlast_err_cleared got %b exp 00", b_resp); end
        axi_read(4'h6, 32'h500, 8'd4, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e) begin
                n_fail++; $display("FAIL wlast_readback[%0d] got %h exp %h", i, rd_data[i], e);
            end
        end
    endtask

    task automatic test_fixed_alias;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 4; i++) begin wr_data.push_back(32'h10 + 32'(i)); wr_strb.push_back(4'hF); end
        axi_write(4'h8, 32'h600, 8'd3, 3'd2, 2'b00, 3);
        axi_read(4'h8, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (rd_data.size() !== 1 || rd_data[0] !== e || rd_data[0] !== 32'h13) begin
            n_fail++; $display("FAIL fixed_word got %h exp 00000013", rd_data.size() ? rd_data[0] : 32'hx);
        end
        // 0x4100 aliases onto 0x100 with a 4K-word RAM; rready toggles randomly.
        axi_read(4'hA, 32'h4100, 8'd7, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e || rd_data[i] !== 32'(i)) begin
                n_fail++; $display("FAIL alias_rdata[%0d] got %h exp %h", i, rd_data[i], e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 2; i++) begin wr_data.push_back(32'hB0 + 32'(i)); wr_strb.push_back(4'hF); end
        fork
            axi_read(4'hC, 32'h100, 8'd7, 3'd2, 2'b01, 1'b0);
            axi_write(4'hD, 32'h700, 8'd1, 3'd2, 2'b01, 1);
        join
        n_tests++;
        if (!(ar_time < aw_time)) begin
            n_fail++; $display("FAIL ar_before_aw got ar=%0t aw=%0t exp ar<aw", ar_time, aw_time);
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data[i] !== e) begin
                n_fail++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rd_data[i], e);
            end
        end
        n_tests++;
        if (b_resp !== 2'b00 || b_id !== 4'hD) begin
            n_fail++; $display("FAIL b2b_bresp got %b/%h exp 00/d", b_resp, b_id);
        end
    endtask

    task automatic test_reset_mid_read;
        @(posedge aclk); #1;
        bus.arid = 4'h1; bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge aclk);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_rvalid got %b exp 1", bus.rvalid); end
        #1 aresetn = 1'b0;
        #1;
        n_tests++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async got rvalid=%b arready=%b exp 0/0", bus.rvalid, bus.arready);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        bus.rready = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle got arready=%b rvalid=%b exp 1/0", bus.arready, bus.rvalid);
        end
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        test_reset();
        test_incr_read();
        test_incr_write();
        test_wrap();
        test_strobe();
        test_wlast_err();
        test_fixed_alias();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
